// File: rtl/alu_pkg.sv
// Shared ALU control definitions: RV32I opcode/funct constants, op_sel/bool_op
// encodings and the decoded control bundle carried through the issue buffer.
package alu_pkg;

  localparam int ALU_XLEN   = 32;
  localparam int ALU_REG_AW = 5;

  localparam logic [3:0] SEL_NONE  = 4'b0000;
  localparam logic [3:0] SEL_ADD   = 4'b0001;
  localparam logic [3:0] SEL_CMP   = 4'b0010;
  localparam logic [3:0] SEL_BOOL  = 4'b0100;
  localparam logic [3:0] SEL_SHIFT = 4'b1000;

  localparam logic [1:0] BOOL_XOR = 2'b00;
  localparam logic [1:0] BOOL_OR  = 2'b10;
  localparam logic [1:0] BOOL_AND = 2'b11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [ALU_XLEN-1:0]   op_a;
    logic [ALU_XLEN-1:0]   op_b;
    logic                  sub;
    logic [1:0]            bool_op;
    logic [3:0]            op_sel;
    logic                  shift_dir;
    logic                  cmp_sig;
    logic [ALU_REG_AW-1:0] rd;
    logic                  illegal;
  } alu_ctrl_t;

  function automatic logic [ALU_XLEN-1:0] sext_imm12(input logic [11:0] imm);
    return {{(ALU_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC into the ALU
// control bundle; anything outside that set becomes an illegal bundle.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0]           inst,
  input  logic [ALU_XLEN-1:0]   pc,
  input  logic [ALU_XLEN-1:0]   rs1_data,
  input  logic [ALU_XLEN-1:0]   rs2_data,
  output logic [ALU_REG_AW-1:0] rs1_addr,
  output logic [ALU_REG_AW-1:0] rs2_addr,
  output alu_ctrl_t             ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       legal;
  logic       is_reg_imm;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  // On OP-IMM only the right shifts carry a funct7; elsewhere those bits are immediate.
  assign alt = (opcode == OPC_OP) ? funct7[5]
             : ((funct3 == F3_SRL_SRA) ? funct7[5] : 1'b0);

  always_comb begin
    ctrl       = '0;
    legal      = 1'b1;
    is_reg_imm = 1'b0;

    case (opcode)
      OPC_OP: begin
        is_reg_imm = 1'b1;
        ctrl.op_a  = rs1_data;
        ctrl.op_b  = rs2_data;
        if (funct7 == F7_ALT) begin
          legal = (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
        end else begin
          legal = (funct7 == F7_BASE);
        end
      end
      OPC_OP_IMM: begin
        is_reg_imm = 1'b1;
        ctrl.op_a  = rs1_data;
        if ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) begin
          ctrl.op_b = {{(ALU_XLEN-5){1'b0}}, inst[24:20]};
        end else begin
          ctrl.op_b = sext_imm12(inst[31:20]);
        end
        if (funct3 == F3_SLL) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
      end
      OPC_LUI: begin
        ctrl.op_b   = {inst[31:12], 12'h000};
        ctrl.op_sel = SEL_ADD;
      end
      OPC_AUIPC: begin
        ctrl.op_a   = pc;
        ctrl.op_b   = {inst[31:12], 12'h000};
        ctrl.op_sel = SEL_ADD;
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    if (is_reg_imm) begin
      case (funct3)
        F3_ADD_SUB: begin
          ctrl.op_sel = SEL_ADD;
          ctrl.sub    = alt;
        end
        F3_SLL: begin
          ctrl.op_sel = SEL_SHIFT;
        end
        F3_SLT: begin
          ctrl.op_sel  = SEL_CMP;
          ctrl.sub     = 1'b1;
          ctrl.cmp_sig = 1'b1;
        end
        F3_SLTU: begin
          ctrl.op_sel = SEL_CMP;
          ctrl.sub    = 1'b1;
        end
        F3_XOR: begin
          ctrl.op_sel  = SEL_BOOL;
          ctrl.bool_op = BOOL_XOR;
        end
        F3_SRL_SRA: begin
          ctrl.op_sel    = SEL_SHIFT;
          ctrl.shift_dir = 1'b1;
          ctrl.sub       = alt;
        end
        F3_OR: begin
          ctrl.op_sel  = SEL_BOOL;
          ctrl.bool_op = BOOL_OR;
        end
        F3_AND: begin
          ctrl.op_sel  = SEL_BOOL;
          ctrl.bool_op = BOOL_AND;
        end
        default: begin
          ctrl.op_sel = SEL_NONE;
        end
      endcase
    end

    ctrl.rd = inst[11:7];

    // Illegal bundles still travel the handshake but carry no operation or destination.
    if (!legal) begin
      ctrl         = '0;
      ctrl.op_sel  = SEL_NONE;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the incoming instruction and holds the bundle in a
// two-entry skid buffer so that o_ready is a register, not a path from i_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = ALU_XLEN,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  output logic [REG_AW-1:0] o_rs1_addr,
  output logic [REG_AW-1:0] o_rs2_addr,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_op_a,
  output logic [XLEN-1:0]   o_op_b,
  output logic              o_sub,
  output logic [1:0]        o_bool_op,
  output logic [3:0]        o_op_sel,
  output logic              o_shift_dir,
  output logic              o_cmp_sig,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_illegal
);

  alu_ctrl_t dec;
  alu_ctrl_t m_q, m_d;
  alu_ctrl_t s_q, s_d;
  logic      m_valid_q, m_valid_d;
  logic      s_valid_q, s_valid_d;
  logic      ready_q;
  logic      fire_in;
  logic      fire_out;

  alu_decoder u_decoder (
    .inst     (i_inst),
    .pc       (i_pc),
    .rs1_data (i_rs1_data),
    .rs2_data (i_rs2_data),
    .rs1_addr (o_rs1_addr),
    .rs2_addr (o_rs2_addr),
    .ctrl     (dec)
  );

  assign fire_in  = i_valid & ready_q;
  assign fire_out = m_valid_q & i_ready;

  // M always drains from S first, so instructions leave in arrival order.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;

    if (i_flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || fire_out) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (fire_in) begin
        m_d       = dec;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (fire_in) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= !s_valid_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = m_valid_q;
  assign o_op_a      = m_q.op_a;
  assign o_op_b      = m_q.op_b;
  assign o_sub       = m_q.sub;
  assign o_bool_op   = m_q.bool_op;
  assign o_op_sel    = m_q.op_sel;
  assign o_shift_dir = m_q.shift_dir;
  assign o_cmp_sig   = m_q.cmp_sig;
  assign o_rd        = m_q.rd;
  assign o_illegal   = m_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: hand-decoded vector table plus stall, flush and
// reset sequences, with a queue scoreboard matching accepted vs emitted bundles.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_op_a;
  logic [31:0] o_op_b;
  logic        o_sub;
  logic [1:0]  o_bool_op;
  logic [3:0]  o_op_sel;
  logic        o_shift_dir;
  logic        o_cmp_sig;
  logic [4:0]  o_rd;
  logic        o_illegal;

  alu_issue_stage dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .o_rs1_addr  (o_rs1_addr),
    .o_rs2_addr  (o_rs2_addr),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_op_a      (o_op_a),
    .o_op_b      (o_op_b),
    .o_sub       (o_sub),
    .o_bool_op   (o_bool_op),
    .o_op_sel    (o_op_sel),
    .o_shift_dir (o_shift_dir),
    .o_cmp_sig   (o_cmp_sig),
    .o_rd        (o_rd),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    alu_ctrl_t   exp;
  } vec_t;

  localparam int NVEC = 18;

  vec_t      vecs [NVEC];
  alu_ctrl_t sb_q [$];
  alu_ctrl_t cur_exp;
  bit        fired_in;
  int        checks = 0;
  int        errors = 0;

  function automatic alu_ctrl_t mk(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [1:0] bop,
                                   input logic [3:0] sel, input logic dir,
                                   input logic cmp, input logic [4:0] rd,
                                   input logic ill);
    alu_ctrl_t c;
    c.op_a = a; c.op_b = b; c.sub = sub; c.bool_op = bop; c.op_sel = sel;
    c.shift_dir = dir; c.cmp_sig = cmp; c.rd = rd; c.illegal = ill;
    return c;
  endfunction

  function automatic vec_t mkv(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input alu_ctrl_t exp);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp;
    return v;
  endfunction

  function automatic alu_ctrl_t actual();
    return mk(o_op_a, o_op_b, o_sub, o_bool_op, o_op_sel, o_shift_dir,
              o_cmp_sig, o_rd, o_illegal);
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act,
                             input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: pop on every accepted output, push on every accepted input.
  task automatic runScoreboard();
    alu_ctrl_t exp;
    fired_in = 1'b0;
    if (!i_rst_n || i_flush) begin
      sb_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got bundle %h, expected no output", actual());
        end else begin
          exp = sb_q.pop_front();
          checkOutput("bundle", 96'(actual()), 96'(exp));
        end
      end
      if (i_valid && o_ready) begin
        sb_q.push_back(cur_exp);
        fired_in = 1'b1;
      end
    end
  endtask

  task automatic sampleNeg();
    @(negedge i_clk);
    runScoreboard();
  endtask

  task automatic advance();
    @(posedge i_clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      sampleNeg();
      advance();
    end
  endtask

  task automatic presentVec(input vec_t v);
    i_valid    = 1'b1;
    i_inst     = v.inst;
    i_pc       = v.pc;
    i_rs1_data = v.rs1;
    i_rs2_data = v.rs2;
    cur_exp    = v.exp;
  endtask

  task automatic applyStimulus(input vec_t v);
    int  n;
    bit  accepted;
    n        = 0;
    accepted = 1'b0;
    presentVec(v);
    while (!accepted && n < 20) begin
      sampleNeg();
      accepted = fired_in;
      advance();
      n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
    end
    i_valid = 1'b0;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_valid"}, 96'(o_valid), 96'(0));
    checkOutput({name, "_ready"}, 96'(o_ready), 96'(1));
    checkOutput({name, "_payload"}, 96'(actual()), 96'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mkv(32'hFFD08293, 32'h0, 32'd10, 32'h0,
                   mk(32'd10, 32'hFFFFFFFD, 0, 2'b00, 4'b0001, 0, 0, 5'd5, 0));
    vecs[1]  = mkv(32'h40815193, 32'h0, 32'h80000000, 32'h0,
                   mk(32'h80000000, 32'd8, 1, 2'b00, 4'b1000, 1, 0, 5'd3, 0));
    vecs[2]  = mkv(32'h0020B3B3, 32'h0, 32'd5, 32'd7,
                   mk(32'd5, 32'd7, 1, 2'b00, 4'b0010, 0, 0, 5'd7, 0));
    vecs[3]  = mkv(32'h123450B7, 32'h0, 32'hDEADBEEF, 32'h1,
                   mk(32'h0, 32'h12345000, 0, 2'b00, 4'b0001, 0, 0, 5'd1, 0));
    vecs[4]  = mkv(32'h00001117, 32'h100, 32'h55, 32'h0,
                   mk(32'h100, 32'h1000, 0, 2'b00, 4'b0001, 0, 0, 5'd2, 0));
    vecs[5]  = mkv(32'h00A0007F, 32'h0, 32'h1234, 32'h5678,
                   mk(32'h0, 32'h0, 0, 2'b00, 4'b0000, 0, 0, 5'd0, 1));
    vecs[6]  = mkv(32'h40208233, 32'h0, 32'd20, 32'd3,
                   mk(32'd20, 32'd3, 1, 2'b00, 4'b0001, 0, 0, 5'd4, 0));
    vecs[7]  = mkv(32'h0F00C313, 32'h0, 32'h0F0F, 32'h0,
                   mk(32'h0F0F, 32'hF0, 0, 2'b00, 4'b0100, 0, 0, 5'd6, 0));
    vecs[8]  = mkv(32'h0020F433, 32'h0, 32'hC, 32'hA,
                   mk(32'hC, 32'hA, 0, 2'b11, 4'b0100, 0, 0, 5'd8, 0));
    vecs[9]  = mkv(32'h0020E4B3, 32'h0, 32'hC, 32'hA,
                   mk(32'hC, 32'hA, 0, 2'b10, 4'b0100, 0, 0, 5'd9, 0));
    vecs[10] = mkv(32'h00209533, 32'h0, 32'h1, 32'h4,
                   mk(32'h1, 32'h4, 0, 2'b00, 4'b1000, 0, 0, 5'd10, 0));
    vecs[11] = mkv(32'h0020A5B3, 32'h0, 32'hFFFFFFFF, 32'h1,
                   mk(32'hFFFFFFFF, 32'h1, 1, 2'b00, 4'b0010, 0, 1, 5'd11, 0));
    vecs[12] = mkv(32'h02208633, 32'h0, 32'h3, 32'h4,
                   mk(32'h0, 32'h0, 0, 2'b00, 4'b0000, 0, 0, 5'd0, 1));
    vecs[13] = mkv(32'h4020C6B3, 32'h0, 32'h3, 32'h4,
                   mk(32'h0, 32'h0, 0, 2'b00, 4'b0000, 0, 0, 5'd0, 1));
    vecs[14] = mkv(32'h40309713, 32'h0, 32'h3, 32'h4,
                   mk(32'h0, 32'h0, 0, 2'b00, 4'b0000, 0, 0, 5'd0, 1));
    vecs[15] = mkv(32'h01F0D793, 32'h0, 32'h80000000, 32'h0,
                   mk(32'h80000000, 32'd31, 0, 2'b00, 4'b1000, 1, 0, 5'd15, 0));
    vecs[16] = mkv(32'hFFF0B813, 32'h0, 32'd3, 32'h0,
                   mk(32'd3, 32'hFFFFFFFF, 1, 2'b00, 4'b0010, 0, 0, 5'd16, 0));
    vecs[17] = mkv(32'h40008893, 32'h0, 32'd1, 32'h0,
                   mk(32'd1, 32'h400, 0, 2'b00, 4'b0001, 0, 0, 5'd17, 0));

    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_inst = '0; i_pc = '0; i_rs1_data = '0; i_rs2_data = '0;
    cur_exp = '0;
    step(2);
    i_rst_n = 1'b1;
    sampleNeg();
    checkResetState("reset");
    advance();

    // ADDI: combinational register addresses, then one-cycle latency.
    i_ready = 1'b1;
    presentVec(vecs[0]);
    i_valid = 1'b0;
    #1;
    checkOutput("rs1_addr", 96'(o_rs1_addr), 96'(1));
    checkOutput("rs2_addr", 96'(o_rs2_addr), 96'(29));
    applyStimulus(vecs[0]);
    sampleNeg();
    checkOutput("addi_latency_valid", 96'(o_valid), 96'(1));
    advance();

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
    step(3);
    checkOutput("table_drained", 96'(sb_q.size()), 96'(0));

    // Three back-to-back with execute stalled: third must wait upstream.
    i_ready = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[2]);
    presentVec(vecs[3]);
    for (int k = 0; k < 3; k++) begin
      sampleNeg();
      checkOutput("stall_ready", 96'(o_ready), 96'(0));
      checkOutput("stall_valid", 96'(o_valid), 96'(1));
      checkOutput("stall_hold", 96'(actual()), 96'(vecs[0].exp));
      advance();
    end
    i_ready = 1'b1;
    applyStimulus(vecs[3]);
    sampleNeg();
    checkOutput("stall_third_valid", 96'(o_valid), 96'(1));
    checkOutput("stall_third_rd", 96'(o_rd), 96'(1));
    advance();
    step(2);
    checkOutput("stall_drained", 96'(sb_q.size()), 96'(0));

    // Flush with the buffer full and a new instruction offered.
    i_ready = 1'b0;
    applyStimulus(vecs[6]);
    applyStimulus(vecs[7]);
    presentVec(vecs[8]);
    i_flush = 1'b1;
    sampleNeg();
    checkOutput("full_ready", 96'(o_ready), 96'(0));
    advance();
    i_flush = 1'b0;
    i_valid = 1'b0;
    sampleNeg();
    checkOutput("flush_valid", 96'(o_valid), 96'(0));
    checkOutput("flush_ready", 96'(o_ready), 96'(1));
    advance();
    i_ready = 1'b1;
    step(4);

    // Flush on an empty buffer drops the instruction offered that cycle.
    presentVec(vecs[9]);
    i_flush = 1'b1;
    sampleNeg();
    checkOutput("flush_empty_ready", 96'(o_ready), 96'(1));
    advance();
    i_flush = 1'b0;
    i_valid = 1'b0;
    sampleNeg();
    checkOutput("flush_incoming_dropped", 96'(o_valid), 96'(0));
    advance();
    step(2);

    // One-cycle reset while the buffer holds two entries.
    i_ready = 1'b0;
    applyStimulus(vecs[10]);
    applyStimulus(vecs[11]);
    i_rst_n = 1'b0;
    step(1);
    i_rst_n = 1'b1;
    sampleNeg();
    checkResetState("midreset");
    advance();
    i_ready = 1'b1;
    step(4);
    applyStimulus(vecs[1]);
    step(2);
    checkOutput("final_drained", 96'(sb_q.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts one RV32I instruction per cycle with its PC and register-file read data, and decodes OP, OP-IMM, LUI and AUIPC into the ALU control bundle (op_a, op_b, sub, bool_op, op_sel, shift_dir, cmp_sig).
- Holds the decoded bundle in a registered two-entry skid buffer with valid/ready on both sides, so that execute-stage stalls do not create a combinational ready path back to fetch.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous reset, active-low.
- i_flush  in  1  discard all buffered and incoming instructions.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; registered.
- i_inst  in  32  instruction word.
- i_pc  in  XLEN  instruction PC.
- o_rs1_addr  out  REG_AW  combinational decode of i_inst[19:15], to the register file.
- o_rs2_addr  out  REG_AW  combinational decode of i_inst[24:20], to the register file.
- i_rs1_data  in  XLEN  rs1 read data, same cycle as i_inst.
- i_rs2_data  in  XLEN  rs2 read data, same cycle as i_inst.
- o_valid  out  1  bundle valid toward the ALU.
- i_ready  in  1  ALU/execute accepts.
- o_op_a  out  XLEN  ALU operand A.
- o_op_b  out  XLEN  ALU operand B.
- o_sub  out  1  subtract / arithmetic-shift select.
- o_bool_op  out  2  00 xor, 10 or, 11 and.
- o_op_sel  out  4  one-hot: 0001 add/sub, 0010 compare, 0100 boolean, 1000 shift.
- o_shift_dir  out  1  0 left, 1 right.
- o_cmp_sig  out  1  1 signed compare.
- o_rd  out  REG_AW  destination register.
- o_illegal  out  1  instruction not in the supported set.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): both buffer entries invalid. o_valid=0, o_ready=1 on the next cycle. All payload outputs are 0.
- Handshakes: fire_in = i_valid & o_ready; fire_out = o_valid & i_ready.
- Latency: 1 cycle from fire_in to o_valid when the buffer is empty.
- Storage: main entry M drives the outputs; skid entry S. o_ready is registered and equals !S.valid.
- Update rule when !M.valid or fire_out:
  - S valid: M<=S, S cleared.
  - Else if fire_in: M<=decode.
  - Else: M invalid.
- Update rule when M.valid & !i_ready: fire_in loads S<=decode; M is held.
- Simultaneous fire_in and fire_out with S empty: the new entry goes to M; no bubble.
- Full (M and S valid, i_ready=0): o_ready=0, M is stable, and outputs are held unchanged until accepted.
- i_flush has highest priority. Next cycle M and S are invalid and o_ready=1. An instruction presented on the flush cycle is dropped even if fire_in.
- Reset mid-operation: same as flush, plus payload cleared.
- Decode rules:
  - OP: op_a=rs1, op_b=rs2. ADD/SUB: sel 0001, sub=funct7[5]. SLT/SLTU: sel 0010, sub=1, cmp_sig=(funct3==010). XOR/OR/AND: sel 0100, bool_op=funct3[1:0]. SLL/SRL/SRA: sel 1000, shift_dir=funct3[2], sub=funct7[5].
  - OP-IMM: op_b = sign-extended imm[11:0], otherwise as OP. SUBI does not exist, so sub=0 for ADDI. Shifts use op_b = zero-extended shamt[4:0]; sub=1 only for SRAI.
  - LUI: op_a=0, op_b={imm[31:12],12'b0}, sel 0001, sub=0.
  - AUIPC: op_a=i_pc, op_b as LUI, sel 0001, sub=0.
  - Unused controls in each case are 0.
- Illegal instructions set o_illegal=1 with sel 0000 and rd=0; they still flow through the handshake. Illegal means:
  - any other opcode;
  - funct7 not in {0000000, 0100000} on OP;
  - 0100000 with funct3 other than 000/101;
  - bad funct7 on immediate shifts.
- rd=0 is passed through unchanged; the execute stage owns x0 suppression.

Decomposition:
- Shared package alu_pkg: op_sel one-hot constants, bool_op codes, RV32I opcode/funct3 constants, and a packed struct alu_ctrl_t (op_a, op_b, sub, bool_op, op_sel, shift_dir, cmp_sig, rd, illegal) used for both buffer entries.
- One combinational sub-module, alu_decoder (inst, pc, rs1/rs2 data -> alu_ctrl_t). The top module contains only the skid buffer and flush/reset logic.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), rs1_data=10, i_ready=1 -> next cycle o_valid=1, op_a=10, op_b=0xFFFFFFFD, op_sel=0001, sub=0, rd=5, o_rs1_addr=1 combinationally.
- SRAI x3,x2,8 (0x40815193) -> op_sel=1000, shift_dir=1, sub=1, op_b=8, rd=3; SLTU x7,x1,x2 (0x0020B3B3) -> op_sel=0010, sub=1, cmp_sig=0, op_b=rs2_data.
- LUI x1,0x12345 (0x123450B7) -> op_a=0, op_b=0x12345000; AUIPC with pc=0x100 -> op_a=0x100; opcode 0x7F -> o_illegal=1, op_sel=0000.
- Back-to-back 3 instructions with i_ready=0 for 3 cycles -> o_ready drops after the second accept, the third is held upstream, and outputs are stable. i_ready=1 -> all three emerge in order on consecutive cycles with no loss or duplication.
- Full buffer plus i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1, and no flushed instruction ever appears.
- i_rst_n=0 for one cycle mid-stream -> o_valid=0, all payload 0, o_ready=1 afterwards.
